// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB-lite arbiter (CPU = master 0, DMA = master 1).
// Grants change only on hready cycles and only when the owner is idle.
// A hold counter forces a handover to a waiting master after 64 idle-gapped cycles.
// Address phase is muxed by the current owner and write data by the data-phase owner.
module ahb_bus_arbiter (
   input  logic        clk,
   input  logic        hreset_n,
   // request / grant
   input  logic        cpu_req,
   input  logic        dma_req,
   output logic        cpu_ack,
   output logic        dma_ack,
   // master 0 (CPU)
   input  logic [23:0] m0_haddr,
   input  logic        m0_hwrite,
   input  logic [2:0]  m0_hburst,
   input  logic [1:0]  m0_htrans,
   input  logic [7:0]  m0_hwdata,
   // master 1 (DMA)
   input  logic [23:0] m1_haddr,
   input  logic        m1_hwrite,
   input  logic [2:0]  m1_hburst,
   input  logic [1:0]  m1_htrans,
   input  logic [7:0]  m1_hwdata,
   // slave side
   output logic [23:0] haddr,
   output logic        hwrite,
   output logic [2:0]  hburst,
   output logic [1:0]  htrans,
   output logic [7:0]  hwdata,
   input  logic        hready,
   input  logic        hresp,
   input  logic [7:0]  hrdata,
   // shared response path back to both masters
   output logic        m_hready,
   output logic        m_hresp,
   output logic [7:0]  m_hrdata,
   // debug
   output logic [1:0]  owner
);

   localparam int unsigned AW = 24;
   localparam int unsigned DW = 8;
   localparam int unsigned CW = 6;

   localparam logic [1:0] G_NONE = 2'b00;
   localparam logic [1:0] G_CPU  = 2'b01;
   localparam logic [1:0] G_DMA  = 2'b10;

   localparam logic [1:0] HT_IDLE = 2'b00;

   localparam logic [CW-1:0] HOLD_MAX = {CW{1'b1}};

   // last_served encoding
   localparam logic LS_CPU = 1'b0;
   localparam logic LS_DMA = 1'b1;

   logic [1:0]    state_q;
   logic [1:0]    state_d;
   logic [1:0]    d_owner_q;
   logic [1:0]    d_owner_d;
   logic [CW-1:0] hold_cnt_q;
   logic          last_served_q;

   logic          own_req;
   logic          own_idle;
   logic          oth_req;
   logic [1:0]    oth_state;
   logic          force_handover;

   // State register; acks are registered copies of the next state
   always_ff @(posedge clk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q <= G_NONE;
         cpu_ack <= 1'b0;
         dma_ack <= 1'b0;
      end else begin
         state_q <= state_d;
         cpu_ack <= (state_d == G_CPU);
         dma_ack <= (state_d == G_DMA);
      end
   end

   // Next-state logic: arbitration in G_NONE, release/handover when owner idle
   always_comb begin
      state_d        = state_q;
      own_req        = 1'b0;
      own_idle       = 1'b0;
      oth_req        = 1'b0;
      oth_state      = G_NONE;
      force_handover = 1'b0;

      case (state_q)
         G_CPU: begin
            own_req   = cpu_req;
            own_idle  = (m0_htrans == HT_IDLE);
            oth_req   = dma_req;
            oth_state = G_DMA;
         end
         G_DMA: begin
            own_req   = dma_req;
            own_idle  = (m1_htrans == HT_IDLE);
            oth_req   = cpu_req;
            oth_state = G_CPU;
         end
         default: ;
      endcase

      force_handover = (hold_cnt_q == HOLD_MAX) && oth_req && own_idle;

      if (hready) begin
         if (state_q == G_NONE) begin
            if (cpu_req && dma_req) begin
               state_d = (last_served_q == LS_DMA) ? G_CPU : G_DMA;
            end else if (cpu_req) begin
               state_d = G_CPU;
            end else if (dma_req) begin
               state_d = G_DMA;
            end
         end else if ((state_q != G_CPU) && (state_q != G_DMA)) begin
            // unreachable encoding: recover to no grant
            state_d = G_NONE;
         end else if (own_idle && (!own_req || force_handover)) begin
            state_d = oth_req ? oth_state : G_NONE;
         end
      end
   end

   // Address-phase mux from the current owner
   always_comb begin
      haddr  = '0;
      hwrite = 1'b0;
      hburst = '0;
      htrans = HT_IDLE;
      case (state_q)
         G_CPU: begin
            haddr  = m0_haddr;
            hwrite = m0_hwrite;
            hburst = m0_hburst;
            htrans = m0_htrans;
         end
         G_DMA: begin
            haddr  = m1_haddr;
            hwrite = m1_hwrite;
            hburst = m1_hburst;
            htrans = m1_htrans;
         end
         default: ;
      endcase
   end

   // Next data-phase owner: only NONSEQ/SEQ transfers carry a data phase
   always_comb begin
      d_owner_d = G_NONE;
      if (htrans[1]) begin
         d_owner_d = state_q;
      end
   end

   // Write-data mux from the data-phase owner
   always_comb begin
      hwdata = '0;
      case (d_owner_q)
         G_CPU:   hwdata = m0_hwdata;
         G_DMA:   hwdata = m1_hwdata;
         default: hwdata = DW'(0);
      endcase
   end

   // Data-phase owner advances only when the slave accepts the transfer
   always_ff @(posedge clk or negedge hreset_n) begin
      if (!hreset_n) begin
         d_owner_q <= G_NONE;
      end else if (hready) begin
         d_owner_q <= d_owner_d;
      end
   end

   // Hold counter: counts accepted cycles of one tenure, saturating, cleared on any grant change
   always_ff @(posedge clk or negedge hreset_n) begin
      if (!hreset_n) begin
         hold_cnt_q <= '0;
      end else if (hready) begin
         if (state_d != state_q) begin
            hold_cnt_q <= '0;
         end else if ((state_q != G_NONE) && (hold_cnt_q != HOLD_MAX)) begin
            hold_cnt_q <= hold_cnt_q + CW'(1);
         end
      end
   end

   // Remember which master was granted last for tie-breaking
   always_ff @(posedge clk or negedge hreset_n) begin
      if (!hreset_n) begin
         last_served_q <= LS_DMA;
      end else if (hready && (state_d != state_q)) begin
         if (state_d == G_CPU) begin
            last_served_q <= LS_CPU;
         end else if (state_d == G_DMA) begin
            last_served_q <= LS_DMA;
         end
      end
   end

   // Response path and debug outputs
   always_comb begin
      m_hready = hready;
      m_hresp  = hresp;
      m_hrdata = hrdata;
      owner    = state_q;
   end

   // address width sanity for the mux above
   logic [AW-1:0] unused_aw;
   always_comb unused_aw = haddr;

endmodule

// File: doc/ahb_bus_arbiter.md
AHB_BUS_ARBITER -- requirements
Module: ahb_bus_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port hreset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have ports cpu_req/dma_req, input, 1 bit each: bus request from CPU bus interface (master 0) and DMA (master 1).
REQ-004 SHALL have ports cpu_ack/dma_ack, output, 1 bit each: grant to that master.
REQ-005 SHALL have per-master inputs m*_haddr[23:0], m*_hwrite, m*_hburst[2:0], m*_htrans[1:0], m*_hwdata[7:0] (m0 = CPU, m1 = DMA).
REQ-006 SHALL have slave-side outputs haddr[23:0], hwrite, hburst[2:0], htrans[1:0], hwdata[7:0].
REQ-007 SHALL have slave-side inputs hready, hresp, hrdata[7:0], passed combinationally to both masters as m_hready, m_hresp, m_hrdata.
REQ-008 SHALL have output owner[1:0]: current grant state, for debug.

Function
REQ-009 SHALL implement states G_NONE (00), G_CPU (01) and G_DMA (10).
REQ-010 Transitions SHALL occur only on clk edges where hready=1.
REQ-011 In G_NONE: only dma_req -> G_DMA; only cpu_req -> G_CPU; both -> the master not recorded in last_served.
REQ-012 An owner SHALL be released only when its req=0 or its m_htrans=IDLE (00); never while htrans is NONSEQ (10), SEQ (11) or BUSY (01).
REQ-013 On release with the other master requesting: SHALL go directly to the other master's state with no G_NONE cycle; otherwise -> G_NONE, or stay if the owner's req=1.
REQ-014 Starvation guard: hold_cnt (6 bits) SHALL count hready cycles in G_CPU/G_DMA and clear on any state change.
REQ-015 When hold_cnt=63, the other master requests and the owner's htrans=IDLE, the handover SHALL be forced even if the owner's req=1.
REQ-016 last_served SHALL update to the granted master on every entry into G_CPU/G_DMA.
REQ-017 Address phase: haddr/hwrite/hburst/htrans SHALL be combinationally muxed from the owner.
REQ-018 In G_NONE, address-phase outputs SHALL be haddr=0, hwrite=0, hburst=0, htrans=IDLE.
REQ-019 Data phase: d_owner SHALL register the owner on hready=1 when the muxed htrans is NONSEQ/SEQ, else d_owner=none.
REQ-020 hwdata SHALL be muxed by d_owner, and SHALL be 0 when d_owner=none.
REQ-021 A grant change SHALL NOT alter hwdata of an in-flight data phase; the old owner's data SHALL complete while the new owner drives its address.
REQ-022 cpu_ack = (owner==G_CPU), dma_ack = (owner==G_DMA), both registered; they SHALL never be 1 simultaneously.
REQ-023 While hready=0 (wait states), owner, d_owner and hold_cnt SHALL be frozen.
REQ-024 hresp=1 SHALL NOT itself change the grant; the master handles the error and drops htrans to IDLE.

Reset
REQ-025 On hreset_n=0, immediately (asynchronously) and including mid-burst: owner=G_NONE, d_owner=none, hold_cnt=0, last_served=DMA (so the CPU wins the first tie), cpu_ack=dma_ack=0, htrans=IDLE, haddr=0, hwdata=0.
REQ-026 The first grant SHALL be possible on the first clk edge after hreset_n deasserts, subject to REQ-010.

Verification
REQ-027 Both req rise together after reset, hready=1 -> cpu_ack=1 next edge, dma_ack=0; CPU drops req -> dma_ack=1 next edge, no G_NONE gap.
REQ-028 DMA owns bus, NONSEQ addr 0x000010 then SEQ, dma_req dropped mid-burst -> dma_ack stays 1 until DMA htrans=IDLE, then 0.
REQ-029 CPU write 0xA5 at 0xC00004 with hready=0 for 3 cycles, handover pending -> grant frozen 3 cycles; hwdata=0xA5 held until hready=1; DMA address driven the following cycle.
REQ-030 CPU holds req continuously with htrans=IDLE gaps, DMA requesting -> forced handover at hold_cnt=63, i.e. dma_ack=1 on the 64th hready cycle.
REQ-031 hreset_n pulsed low mid-burst while DMA owner -> acks 0, htrans=IDLE, hwdata=0 without waiting for a clk edge; after release, both requesting -> CPU granted.
REQ-032 Random req/htrans/hready traffic, 10k cycles -> never both acks high; grant never changes while hready=0 or while the owner's htrans≠IDLE with req=1 (except the REQ-015 force case).
